// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: increment, jump, conditional branch, call/return
// through a circular return-address stack, with stall hold and sticky RAS errors.
module pc_seq_unit #(
   parameter int unsigned             WIDTH      = 32,
   parameter logic [WIDTH-1:0]        RESET_ADDR = '0,
   parameter int unsigned             STEP       = 4,
   parameter int unsigned             RAS_DEPTH  = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             jmpFlag,
   input  logic             callFlag,
   input  logic             retFlag,
   input  logic [WIDTH-1:0] jmpAddress,
   input  logic             branchFlag,
   input  logic [1:0]       branchMode,
   input  logic             zeroFlag,
   input  logic [WIDTH-1:0] branchOffset,
   output logic [WIDTH-1:0] address,
   output logic             resetControl,
   output logic             rasEmpty,
   output logic             rasFull,
   output logic             rasOverflow,
   output logic             rasUnderflow
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_RESET = 2'd1;
   localparam logic [1:0] S_POST  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] ras [RAS_DEPTH];
   logic [PW-1:0]    top;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] seq_addr;
   logic [WIDTH-1:0] next_addr;
   logic [PW-1:0]    wr_idx;
   logic             taken;
   logic             push;
   logic             pop;
   logic             replace;
   logic             set_ovf;
   logic             set_unf;

   assign rasEmpty     = (count == '0);
   assign rasFull      = (count == CW'(RAS_DEPTH));
   assign resetControl = (state != S_RUN);

   always_comb begin
      taken = 1'b0;
      case (branchMode)
         2'b00:   taken = zeroFlag;
         2'b01:   taken = ~zeroFlag;
         2'b10:   taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      seq_addr  = address + WIDTH'(STEP);
      next_addr = address;
      push      = 1'b0;
      pop       = 1'b0;
      replace   = 1'b0;
      set_ovf   = 1'b0;
      set_unf   = 1'b0;
      // The first edge after reset release ignores every control input.
      if (state != S_RESET && !stall) begin
         if (retFlag && callFlag) begin
            next_addr = jmpAddress;
            if (rasEmpty) push = 1'b1;
            else          replace = 1'b1;
         end else if (retFlag) begin
            if (!rasEmpty) begin
               next_addr = ras[top];
               pop       = 1'b1;
            end else begin
               next_addr = seq_addr;
               set_unf   = 1'b1;
            end
         end else if (callFlag) begin
            next_addr = jmpAddress;
            push      = 1'b1;
            set_ovf   = rasFull;
         end else if (jmpFlag) begin
            next_addr = jmpAddress;
         end else if (branchFlag && taken) begin
            next_addr = address + branchOffset;
         end else begin
            next_addr = seq_addr;
         end
      end
      wr_idx = push ? top + PW'(1) : top;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_RESET;
         address      <= RESET_ADDR;
         top          <= '0;
         count        <= '0;
         rasOverflow  <= 1'b0;
         rasUnderflow <= 1'b0;
      end else begin
         case (state)
            S_RESET: state <= S_POST;
            default: state <= S_RUN;
         endcase
         address <= next_addr;
         if (push) begin
            top <= top + PW'(1);
            // A push while full overwrites the oldest slot; count saturates.
            if (!rasFull) count <= count + CW'(1);
         end else if (pop) begin
            top   <= top - PW'(1);
            count <= count - CW'(1);
         end
         if (set_ovf) rasOverflow  <= 1'b1;
         if (set_unf) rasUnderflow <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && (push || replace)) ras[wr_idx] <= seq_addr;
   end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed table-driven bench for pc_seq_unit (WIDTH=32, RESET_ADDR=0, STEP=4, RAS_DEPTH=4).
module tb_pc_seq_unit;

   localparam logic [4:0] IDLE = 5'b00000;
   localparam logic [4:0] RST  = 5'b10000;
   localparam logic [4:0] STL  = 5'b01000;
   localparam logic [4:0] JMP  = 5'b00100;
   localparam logic [4:0] CAL  = 5'b00010;
   localparam logic [4:0] RET  = 5'b00001;

   typedef struct {
      logic [4:0]  ctl;   // rst, stall, jmp, call, ret
      logic [31:0] ja;
      logic [3:0]  brm;   // branchFlag, branchMode[1:0], zeroFlag
      logic [31:0] off;
      logic [31:0] ea;
      logic [4:0]  fl;    // resetControl, rasEmpty, rasFull, rasOverflow, rasUnderflow
   } vec_t;

   logic        clock = 1'b0;
   logic        reset, stall, jmpFlag, callFlag, retFlag, branchFlag, zeroFlag;
   logic [31:0] jmpAddress, branchOffset, address;
   logic [1:0]  branchMode;
   logic        resetControl, rasEmpty, rasFull, rasOverflow, rasUnderflow;

   int total = 0;
   int bad   = 0;
   vec_t vq[$];

   pc_seq_unit #(.WIDTH(32), .RESET_ADDR(32'h0), .STEP(4), .RAS_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .stall(stall), .jmpFlag(jmpFlag),
      .callFlag(callFlag), .retFlag(retFlag), .jmpAddress(jmpAddress),
      .branchFlag(branchFlag), .branchMode(branchMode), .zeroFlag(zeroFlag),
      .branchOffset(branchOffset), .address(address), .resetControl(resetControl),
      .rasEmpty(rasEmpty), .rasFull(rasFull), .rasOverflow(rasOverflow),
      .rasUnderflow(rasUnderflow)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(logic [4:0] ctl, logic [31:0] ja, logic [3:0] brm,
                               logic [31:0] off, logic [31:0] ea, logic [4:0] fl);
      vec_t v;
      v.ctl = ctl; v.ja = ja; v.brm = brm; v.off = off; v.ea = ea; v.fl = fl;
      return v;
   endfunction

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic apply(vec_t v, int idx);
      {reset, stall, jmpFlag, callFlag, retFlag} = v.ctl;
      jmpAddress   = v.ja;
      {branchFlag, branchMode, zeroFlag} = v.brm;
      branchOffset = v.off;
      @(posedge clock);
      #1;
      chk("address",      idx, address,             v.ea);
      chk("resetControl", idx, 32'(resetControl),   32'(v.fl[4]));
      chk("rasEmpty",     idx, 32'(rasEmpty),       32'(v.fl[3]));
      chk("rasFull",      idx, 32'(rasFull),        32'(v.fl[2]));
      chk("rasOverflow",  idx, 32'(rasOverflow),    32'(v.fl[1]));
      chk("rasUnderflow", idx, 32'(rasUnderflow),   32'(v.fl[0]));
   endtask

   initial begin
      // reset, release, sequential increment
      vq.push_back(mk(RST,  0, 4'b0000, 0, 32'h0,    5'b11000));
      vq.push_back(mk(IDLE, 0, 4'b0000, 0, 32'h0,    5'b11000));
      vq.push_back(mk(IDLE, 0, 4'b0000, 0, 32'h4,    5'b01000));
      vq.push_back(mk(IDLE, 0, 4'b0000, 0, 32'h8,    5'b01000));
      // absolute jump
      vq.push_back(mk(JMP, 32'hFFC, 4'b0000, 0, 32'hFFC,  5'b01000));
      vq.push_back(mk(IDLE, 0,      4'b0000, 0, 32'h1000, 5'b01000));
      // branch modes from 0x10 with offset -8
      vq.push_back(mk(JMP, 32'h10, 4'b0000, 0,            32'h10, 5'b01000));
      vq.push_back(mk(IDLE, 0,     4'b1001, 32'hFFFFFFF8, 32'h8,  5'b01000));
      vq.push_back(mk(JMP, 32'h10, 4'b0000, 0,            32'h10, 5'b01000));
      vq.push_back(mk(IDLE, 0,     4'b1011, 32'hFFFFFFF8, 32'h14, 5'b01000));
      vq.push_back(mk(JMP, 32'h10, 4'b0000, 0,            32'h10, 5'b01000));
      vq.push_back(mk(IDLE, 0,     4'b1100, 32'hFFFFFFF8, 32'h8,  5'b01000));
      vq.push_back(mk(JMP, 32'h10, 4'b0000, 0,            32'h10, 5'b01000));
      vq.push_back(mk(IDLE, 0,     4'b1111, 32'hFFFFFFF8, 32'h14, 5'b01000));
      vq.push_back(mk(JMP, 32'h10, 4'b0000, 0,            32'h10, 5'b01000));
      vq.push_back(mk(IDLE, 0,     4'b0101, 32'hFFFFFFF8, 32'h14, 5'b01000));
      vq.push_back(mk(JMP, 32'h10, 4'b0000, 0,            32'h10, 5'b01000));
      vq.push_back(mk(IDLE, 0,     4'b1000, 32'hFFFFFFF8, 32'h14, 5'b01000));
      vq.push_back(mk(JMP, 32'h10, 4'b0000, 0,            32'h10, 5'b01000));
      vq.push_back(mk(IDLE, 0,     4'b1010, 32'hFFFFFFF8, 32'h8,  5'b01000));
      // nested calls and returns
      vq.push_back(mk(JMP, 32'h20,  4'b0000, 0, 32'h20,  5'b01000));
      vq.push_back(mk(CAL, 32'h100, 4'b0000, 0, 32'h100, 5'b00000));
      vq.push_back(mk(CAL, 32'h200, 4'b0000, 0, 32'h200, 5'b00000));
      vq.push_back(mk(RET, 0,       4'b0000, 0, 32'h104, 5'b00000));
      vq.push_back(mk(RET, 0,       4'b0000, 0, 32'h24,  5'b01000));
      // five calls, five returns
      vq.push_back(mk(CAL, 32'h300, 4'b0000, 0, 32'h300, 5'b00000));
      vq.push_back(mk(CAL, 32'h400, 4'b0000, 0, 32'h400, 5'b00000));
      vq.push_back(mk(CAL, 32'h500, 4'b0000, 0, 32'h500, 5'b00000));
      vq.push_back(mk(CAL, 32'h600, 4'b0000, 0, 32'h600, 5'b00100));
      vq.push_back(mk(CAL, 32'h700, 4'b0000, 0, 32'h700, 5'b00110));
      vq.push_back(mk(RET, 0,       4'b0000, 0, 32'h604, 5'b00010));
      vq.push_back(mk(RET, 0,       4'b0000, 0, 32'h504, 5'b00010));
      vq.push_back(mk(RET, 0,       4'b0000, 0, 32'h404, 5'b00010));
      vq.push_back(mk(RET, 0,       4'b0000, 0, 32'h304, 5'b01010));
      vq.push_back(mk(RET, 0,       4'b0000, 0, 32'h308, 5'b01011));
      // stall while calling discards the call
      vq.push_back(mk(CAL,       32'h900, 4'b0000, 0, 32'h900, 5'b00011));
      vq.push_back(mk(STL | CAL, 32'hA00, 4'b0000, 0, 32'h900, 5'b00011));
      vq.push_back(mk(STL | CAL, 32'hA00, 4'b0000, 0, 32'h900, 5'b00011));
      vq.push_back(mk(STL | CAL, 32'hA00, 4'b0000, 0, 32'h900, 5'b00011));
      vq.push_back(mk(RET,       0,       4'b0000, 0, 32'h30C, 5'b01011));
      // call+return replaces top; on empty stack acts as call
      vq.push_back(mk(CAL,       32'h800, 4'b0000, 0, 32'h800, 5'b00011));
      vq.push_back(mk(CAL | RET, 32'h880, 4'b0000, 0, 32'h880, 5'b00011));
      vq.push_back(mk(RET,       0,       4'b0000, 0, 32'h804, 5'b01011));
      vq.push_back(mk(CAL | RET, 32'h900, 4'b0000, 0, 32'h900, 5'b00011));
      vq.push_back(mk(RET,       0,       4'b0000, 0, 32'h808, 5'b01011));
      // jump beats branch
      vq.push_back(mk(JMP, 32'h40, 4'b1100, 32'h100, 32'h40, 5'b01011));
      // reset mid call burst, post-reset cycle ignores a call
      vq.push_back(mk(CAL,             32'h50,  4'b0000, 0, 32'h50, 5'b00011));
      vq.push_back(mk(CAL,             32'h60,  4'b0000, 0, 32'h60, 5'b00011));
      vq.push_back(mk(RST | STL | CAL, 32'h70,  4'b0000, 0, 32'h0,  5'b11000));
      vq.push_back(mk(CAL,             32'h123, 4'b0000, 0, 32'h0,  5'b11000));
      vq.push_back(mk(IDLE,            0,       4'b0000, 0, 32'h4,  5'b01000));
      vq.push_back(mk(RET,             0,       4'b0000, 0, 32'h8,  5'b01001));

      for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

      // multi-cycle reset then release
      apply(mk(RST,  0, 4'b0000, 0, 32'h0, 5'b11000), 100);
      apply(mk(RST,  0, 4'b0000, 0, 32'h0, 5'b11000), 101);
      apply(mk(RST,  0, 4'b0000, 0, 32'h0, 5'b11000), 102);
      apply(mk(IDLE, 0, 4'b0000, 0, 32'h0, 5'b11000), 103);
      apply(mk(IDLE, 0, 4'b0000, 0, 32'h4, 5'b01000), 104);

      // address wrap through increment and branch
      apply(mk(JMP,  32'hFFFFFFF8, 4'b0000, 0,            32'hFFFFFFF8, 5'b01000), 200);
      apply(mk(IDLE, 0,            4'b0000, 0,            32'hFFFFFFFC, 5'b01000), 201);
      apply(mk(IDLE, 0,            4'b0000, 0,            32'h0,        5'b01000), 202);
      apply(mk(IDLE, 0,            4'b1100, 32'hFFFFFFF8, 32'hFFFFFFF8, 5'b01000), 203);
      apply(mk(IDLE, 0,            4'b1100, 32'h10,       32'h8,        5'b01000), 204);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter sequencer for the MIPS CPU core, successor to the single-width `pc` block. Selects next fetch address from sequential increment, absolute jump, conditional relative branch (selectable condition), call and return. Call/return targets come from an internal return-address stack (RAS). Adds a pipeline stall hold and sticky RAS error flags.

## Interface
- `WIDTH`, 32, address/offset width in bits
- `RESET_ADDR`, 0, address loaded on reset
- `STEP`, 4, sequential increment in bytes
- `RAS_DEPTH`, 4, return-address stack entries (≥2, power of two)

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  hold all state this cycle
- `jmpFlag`  in  1  absolute jump to `jmpAddress`
- `callFlag`  in  1  jump to `jmpAddress` and push return address
- `retFlag`  in  1  pop RAS and jump to popped address
- `jmpAddress`  in  WIDTH  jump/call target
- `branchFlag`  in  1  conditional branch request
- `branchMode`  in  2  00 taken if zeroFlag=1; 01 taken if zeroFlag=0; 10 always; 11 never
- `zeroFlag`  in  1  ALU zero result
- `branchOffset`  in  WIDTH  signed byte offset, two's complement
- `address`  out  WIDTH  current fetch address (registered)
- `resetControl`  out  1  high during reset and first cycle after release
- `rasEmpty`  out  1  stack count = 0
- `rasFull`  out  1  stack count = RAS_DEPTH
- `rasOverflow`  out  1  sticky: push while full
- `rasUnderflow`  out  1  sticky: pop while empty

## Operation
- Reset (sampled high): `address`=RESET_ADDR, RAS count=0, both sticky flags 0, `resetControl`=1. Reset overrides every other input, including `stall`.
- Post-reset cycle: `resetControl` stays 1 for exactly one cycle after `reset` falls. `address` holds RESET_ADDR in that cycle; control inputs are ignored.
- Otherwise, next-address priority (highest first):
  1. `stall`: address, RAS and flags hold.
  2. `retFlag` and `callFlag` both high: next = `jmpAddress`. Top entry is replaced by `address+STEP` with count unchanged. If the stack is empty, this acts as a plain call.
  3. `retFlag`: if count>0, next = top and count–1. If empty, next = `address+STEP` and `rasUnderflow` is set.
  4. `callFlag`: next = `jmpAddress` and `address+STEP` is pushed. If full, the oldest entry is overwritten (circular), count stays RAS_DEPTH, and `rasOverflow` is set.
  5. `jmpFlag`: next = `jmpAddress`.
  6. `branchFlag` and condition true per `branchMode`: next = `address + branchOffset`.
  7. Else next = `address + STEP`.
- Arithmetic: all sums are modulo 2^WIDTH. Wrap from max address to 0 is silent. `branchOffset` is added as-is; no shift or sign extension is applied inside the block.
- RAS storage: circular buffer with a top pointer of log2(RAS_DEPTH) bits. `rasEmpty` and `rasFull` derive combinationally from the registered count.
- Sticky flags clear only on reset.

## Timing
- Next address is combinational from current inputs and registered state. It appears on `address` one clock after sampling, giving single-cycle redirect latency for all modes.
- RAS push/pop takes effect on the same edge as the address update. A return issued the cycle after a call pops that call's return address.
- `rasEmpty`/`rasFull` reflect the post-edge count. Sticky flags rise on the edge where the offending op is sampled.
- `stall` high for N cycles holds `address` N cycles. Inputs sampled during a stall are discarded, not queued.
- Reset asserted mid-sequence (e.g. during a call burst) clears RAS on that edge. No pending operation survives.

## Test plan
- Reset 1 cycle, release, run 3 cycles → `address` 0, 0 (`resetControl`=1), 4, 8; `resetControl` 1,1,0,0.
- At 0x8, `jmpFlag`=1, `jmpAddress`=0xFFC, then idle → 0xFFC, then 0x1000.
- At 0x10, `branchOffset`=0xFFFFFFF8:
  - mode 00 with zero=1 → 0x8.
  - mode 01 with zero=1 → 0x14.
  - mode 10 → 0x8.
  - mode 11 → 0x14.
- Nested calls from 0x20 (target 0x100) and from 0x100 (target 0x200), then two returns → 0x100, 0x200, 0x104, 0x24; `rasEmpty` ends 1.
- With RAS_DEPTH=4, five consecutive calls then five returns:
  - Fifth call sets `rasOverflow`.
  - First four returns yield the four newest return addresses.
  - Fifth return sets `rasUnderflow` and advances by STEP.
- Stall for 3 cycles while `callFlag`=1 → `address` and count unchanged. Reset asserted mid-sequence → RAS empty, flags 0, `address`=RESET_ADDR. At `address`=0xFFFFFFFC with no control → wraps to 0x0.
